fifo_stream_reader: RTL and testbench

- Read-side companion for the team's synchronous FIFO.
- Drains the FIFO's pop interface (fifo_rd_en, fifo_rd_data, fifo_empty) and presents the words as a registered valid/ready stream.
- Holds a 2-entry output buffer so that:
  - throughput is 1 word/cycle;
  - no combinational path exists from m_ready to fifo_rd_en.
- Sits between the FIFO and any downstream consumer that applies backpressure.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_stats_counter.sv | 23 ++
 rtl/fifo_stream_reader.sv | 109 ++++++++++
 tb/tb_fifo_stream_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_pkg;

  localparam int RD_BUF_DEPTH = 2;
  localparam int RD_OCC_W     = $clog2(RD_BUF_DEPTH + 1);

  // Encoding equals the number of buffered words, so occupancy is the state itself.
  typedef enum logic [RD_OCC_W-1:0] {
    RD_EMPTY = 2'd0,
    RD_ONE   = 2'd1,
    RD_TWO   = 2'd2
  } rd_state_t;

  function automatic logic [RD_OCC_W-1:0] rd_occupancy(input rd_state_t s);
    return s;
  endfunction

endpackage

// File: rtl/fifo_stats_counter.sv
// Free-running event counter that wraps modulo 2^CNT_WIDTH; cleared only by rst_n.
module fifo_stats_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO pop port into a registered valid/ready stream via a 2-word buffer.
// Optional statistics counters are built when FIFO_RD_STATS_EN is defined.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [RD_OCC_W-1:0]   occupancy
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]  words_out,
  output logic [CNT_WIDTH-1:0]  stall_cycles
`endif
);

  rd_state_t             state_reg, state_next;
  logic [DATA_WIDTH-1:0] buf0_reg, buf0_next;
  logic [DATA_WIDTH-1:0] buf1_reg, buf1_next;
  logic                  push;
  logic                  pop;

  // Pop decision uses only registered state and the FIFO flag, never m_ready;
  // rst_n gates it so the FIFO is left alone while reset is held.
  assign fifo_rd_en = rst_n && !fifo_empty && (state_reg != RD_TWO) && !flush;
  assign push       = fifo_rd_en;
  assign pop        = m_valid && m_ready;

  assign m_valid    = (state_reg != RD_EMPTY);
  assign m_data     = buf0_reg;
  assign occupancy  = rd_occupancy(state_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= RD_EMPTY;
      buf0_reg  <= '0;
      buf1_reg  <= '0;
    end else begin
      state_reg <= state_next;
      buf0_reg  <= buf0_next;
      buf1_reg  <= buf1_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    buf0_next  = buf0_reg;
    buf1_next  = buf1_reg;
    if (flush) begin
      state_next = RD_EMPTY;
    end else begin
      case (state_reg)
        RD_EMPTY: begin
          if (push) begin
            buf0_next  = fifo_rd_data;
            state_next = RD_ONE;
          end
        end
        RD_ONE: begin
          if (push && pop) begin
            buf0_next = fifo_rd_data;
          end else if (push) begin
            buf1_next  = fifo_rd_data;
            state_next = RD_TWO;
          end else if (pop) begin
            state_next = RD_EMPTY;
          end
        end
        RD_TWO: begin
          // Skid word moves to the head; no push is possible while full.
          if (pop) begin
            buf0_next  = buf1_reg;
            state_next = RD_ONE;
          end
        end
        default: state_next = RD_EMPTY;
      endcase
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic stall;
  assign stall = m_valid && !m_ready;

  fifo_stats_counter #(.CNT_WIDTH(CNT_WIDTH)) u_words_out (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .count (words_out)
  );

  fifo_stats_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cycles (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall),
    .count (stall_cycles)
  );
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and a
// negedge monitor checks every stream word, occupancy and pop decision against the model.
module tb_fifo_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [7:0]  fifo_rd_data;
  logic        fifo_rd_en;
  logic        flush;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_ready;
  logic [1:0]  occupancy;
`ifdef FIFO_RD_STATS_EN
  logic [31:0] words_out;
  logic [31:0] stall_cycles;
`endif

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_rd_en   (fifo_rd_en),
    .flush        (flush),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .occupancy    (occupancy)
`ifdef FIFO_RD_STATS_EN
    ,
    .words_out    (words_out),
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];   // upstream FIFO contents
  logic [7:0] exp_q[$];    // words popped from the FIFO but not yet delivered
  bit         pop_pending;
  int         total = 0;
  int         bad = 0;
  int         hs_cnt = 0;
  int         pop_cnt = 0;
  int         exp_occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void refresh();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? 8'h00 : fifo_q[0];
  endfunction

  // Advance to just after the next rising edge and retire the head the DUT consumed there.
  task automatic step();
    @(posedge clk);
    #1;
    if (pop_pending) begin
      fifo_q.delete(0);
      pop_pending = 1'b0;
    end
    refresh();
  endtask

  task automatic load(input logic [7:0] first, input int n);
    logic [7:0] w;
    w = first;
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(w);
      w = w + 8'd1;
    end
    refresh();
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_done", (fifo_q.size() == 0 && exp_q.size() == 0), 1);
  endtask

  // Monitor: inputs are stable from posedge+1 until the next posedge, so negedge sees the
  // exact values the DUT will act on at the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pop_pending = 1'b0;
    end else begin
      exp_occ = exp_q.size();
      chk("occupancy", occupancy, exp_occ);
      chk("m_valid", m_valid, exp_occ != 0);
      chk("fifo_rd_en", fifo_rd_en, !fifo_empty && exp_occ < 2 && !flush);
      if (m_valid && exp_occ != 0) chk("m_data", m_data, exp_q[0]);
      if (m_valid && m_ready) begin
        $display("hs %0d data=%02h", hs_cnt, m_data);
        if (exp_q.size() != 0) exp_q.delete(0);
        hs_cnt++;
      end
      if (flush) exp_q.delete();
      if (fifo_rd_en) begin
        chk("no_underflow", fifo_empty, 0);
        exp_q.push_back(fifo_rd_data);
        pop_cnt++;
        pop_pending = 1'b1;
      end
    end
  end

  initial begin
    int hs0;
    int pc0;
    int sent;
    int budget;

    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b1;
    pop_pending = 1'b0;
    load(8'h11, 3);
    fifo_q[1] = 8'h22;
    fifo_q[2] = 8'h33;
    refresh();

    // Reset state with a non-empty FIFO.
    step();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_fifo_rd_en", fifo_rd_en, 0);

    // Back-to-back delivery of 0x11, 0x22, 0x33.
    step();
    rst_n = 1'b1;
    hs0 = hs_cnt;
    #1;
    chk("first_pop_cycle1", fifo_rd_en, 1);
    repeat (4) step();
    chk("t1_words", hs_cnt - hs0, 3);
    chk("t1_valid_low", m_valid, 0);

    // Backpressure: only two pops, head held, then five consecutive words.
    m_ready = 1'b0;
    pc0 = pop_cnt;
    load(8'hA0, 5);
    repeat (6) step();
    chk("bp_pops", pop_cnt - pc0, 2);
    chk("bp_occupancy", occupancy, 2);
    chk("bp_head", m_data, 8'hA0);
    m_ready = 1'b1;
    hs0 = hs_cnt;
    repeat (5) step();
    chk("bp_no_gaps", hs_cnt - hs0, 5);
    drain(50);

    // Random backpressure over 200 words.
    hs0 = hs_cnt;
    sent = 0;
    budget = 0;
    while (sent < 200 && budget < 5000) begin
      if ($urandom_range(3, 0) != 0) begin
        fifo_q.push_back(sent[7:0]);
        sent++;
      end
      m_ready = ($urandom_range(9, 0) < 6);
      refresh();
      step();
      budget++;
    end
    m_ready = 1'b1;
    drain(1000);
    chk("rand_count", hs_cnt - hs0, 200);

    // Flush with two words buffered; 0x5C must be the next word out.
    m_ready = 1'b0;
    load(8'h5A, 3);
    repeat (4) step();
    chk("fl_occupancy_before", occupancy, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_m_valid", m_valid, 0);
    chk("fl_occupancy", occupancy, 0);
    hs0 = hs_cnt;
    m_ready = 1'b1;
    drain(50);
    chk("fl_delivered", hs_cnt - hs0, 1);

    // Asynchronous reset with two words buffered.
    m_ready = 1'b0;
    load(8'h70, 5);
    repeat (4) step();
    chk("ar_occupancy_before", occupancy, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_m_valid", m_valid, 0);
    chk("ar_fifo_rd_en", fifo_rd_en, 0);
    chk("ar_occupancy", occupancy, 0);
    step();
    step();
    rst_n = 1'b1;
    hs0 = hs_cnt;
    m_ready = 1'b1;
    drain(50);
    chk("ar_remaining", hs_cnt - hs0, 3);

`ifdef FIFO_RD_STATS_EN
    // Counters: ten words with three stalled cycles, counted from a fresh reset.
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_ready = 1'b1;
    load(8'h80, 10);
    step();
    m_ready = 1'b0;
    repeat (3) step();
    m_ready = 1'b1;
    drain(50);
    chk("words_out", words_out, 10);
    chk("stall_cycles", stall_cycles, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
